memory_access_unit: RTL and testbench
=====================================

Name: memory_access_unit

Overview:
- Memory stage of the five-stage pipeline. Sits directly downstream of the execute/memory pipeline register.
- Takes the *_memory control and datapath signals and runs loads and stores on a waitrequest-style data bus.
- Aligns and extends load data, and stalls the pipeline until the bus access completes.
- Results feed the memory/writeback register.

Parameters:
- TIMEOUT_CYCLES, 255: max BUSY cycles before abort (used only when the optional feature is compiled in).

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- memory_to_register_memory  input  1  load request
- memory_write_memory  input  1  store request
- load_store_type_memory  input  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
- ALU_output_memory  input  32  byte address
- write_data_memory  input  32  store data (rt)
- data_address  output  32  word-aligned bus address
- data_read  output  1  bus read strobe
- data_write  output  1  bus write strobe
- data_writedata  output  32  lane-positioned store data
- data_byteenable  output  4  active lanes
- data_readdata  input  32  bus read data
- data_waitrequest  input  1  high = bus not yet accepting/completing
- read_data_memory  output  32  aligned, extended load result
- stall_memory  output  1  freeze PC and all pipeline registers upstream of memory/writeback
- address_error_memory  output  1  misaligned access flag

Behaviour:
- Reset (async, reset_n=0): state IDLE; data_read=0, data_write=0, data_address=0, data_writedata=0, data_byteenable=0, read_data_memory=0. Bus strobes drop immediately, including mid-access. The access is abandoned, not retried.
- Request: memory_to_register_memory | memory_write_memory. If both are high, the load wins and no write strobe is issued.
- Misaligned request: word with addr[1:0]!=0, or half with addr[0]=1.
  - address_error_memory=1 combinationally.
  - No bus access and no stall; FSM stays IDLE.
- FSM states and transitions:
  - IDLE: an aligned request sets stall_memory=1 combinationally. On the clock edge, register address {addr[31:2],2'b00}, byteenable, writedata and strobe, then go to BUSY.
  - BUSY: strobes and all bus outputs held stable; stall_memory=1. Stay while data_waitrequest=1. When data_waitrequest=0: drop strobes; for a load, capture the extended data into read_data_memory; go to DONE.
  - DONE: stall_memory=0 so the pipeline advances on this edge; read_data_memory valid; return to IDLE.
  - Minimum cost per access: 2 stall cycles (IDLE, BUSY with waitrequest=0).
- Bus endianness is little-endian: byte offset n maps to lane n (bits 8n+7:8n).
- Store lane rules:
  - Word: byteenable 1111.
  - Half: offset 0 -> 0011, offset 2 -> 1100; halfword replicated in both halves.
  - Byte: byteenable one-hot at offset; byte replicated in all four lanes.
- Load rules:
  - Select the lane(s) by offset, then sign- or zero-extend per type.
  - read_data_memory holds its value until the next load completes. Stores do not change it.
- Non-request cycle: no strobes, stall_memory=0, FSM stays IDLE.

Optional Feature:
- Macro: DATA_BUS_TIMEOUT_EN.
- With the macro: an 8-bit saturating counter runs in BUSY. When it reaches TIMEOUT_CYCLES with waitrequest still 1:
  - drop strobes and go to DONE;
  - read_data_memory=32'hDEADBEEF;
  - extra output bus_timeout_memory pulses 1 for the DONE cycle.
  - The counter clears on every entry to BUSY.
- Without the macro: BUSY waits indefinitely, and the bus_timeout_memory port does not exist.

Test Plan:
- Word load, addr 0x100, readdata 0x11223344, waitrequest 0 -> data_read for 1 cycle at 0x100, stall 2 cycles, read_data_memory=0x11223344.
- Byte signed load, addr 0x103, readdata 0x80FF0000 -> byteenable 1000, read_data_memory=0xFFFFFF80; same access as unsigned -> 0x00000080.
- Half store 0xABCD to addr 0x202, waitrequest high 3 cycles -> address 0x200, byteenable 1100, writedata 0xABCDABCD held stable, stall 5 cycles total.
- Word load at addr 0x102 -> address_error_memory=1, no strobes, stall_memory=0.
- reset_n low during BUSY -> data_read falls without clock, outputs all 0. After release, the next request starts a fresh access.
- DATA_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, waitrequest stuck 1 -> abort after 4 BUSY cycles, read_data_memory=0xDEADBEEF, bus_timeout_memory pulse.

Source files
------------

// File: rtl/memory_access_unit.sv
// Memory stage: runs loads/stores on a waitrequest data bus, aligns/extends load data, stalls upstream.
// Optional DATA_BUS_TIMEOUT_EN adds a BUSY watchdog and the bus_timeout_memory output.
module memory_access_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_to_register_memory,
    input  logic        memory_write_memory,
    input  logic [2:0]  load_store_type_memory,
    input  logic [31:0] ALU_output_memory,
    input  logic [31:0] write_data_memory,
    output logic [31:0] data_address,
    output logic        data_read,
    output logic        data_write,
    output logic [31:0] data_writedata,
    output logic [3:0]  data_byteenable,
    input  logic [31:0] data_readdata,
    input  logic        data_waitrequest,
    output logic [31:0] read_data_memory,
    output logic        stall_memory,
`ifdef DATA_BUS_TIMEOUT_EN
    output logic        bus_timeout_memory,
`endif
    output logic        address_error_memory
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t      r_state;
    logic [1:0]  r_offset;
    logic [2:0]  r_type;
    logic        r_is_load;

    logic        w_request;
    logic        w_misaligned;
    logic        w_start;
    logic [1:0]  w_offset;
    logic [3:0]  w_byteenable;
    logic [31:0] w_writedata;
    logic [15:0] w_lane_half;
    logic [7:0]  w_lane_byte;
    logic [31:0] w_load_value;

    assign w_request = memory_to_register_memory | memory_write_memory;
    assign w_offset  = ALU_output_memory[1:0];

    always_comb begin
        w_misaligned = 1'b0;
        case (load_store_type_memory)
            3'b000:         w_misaligned = |w_offset;
            3'b001, 3'b010: w_misaligned = w_offset[0];
            default:        w_misaligned = 1'b0;
        endcase
    end

    assign w_start              = (r_state == S_IDLE) && w_request && !w_misaligned;
    assign address_error_memory = w_request && w_misaligned;
    assign stall_memory         = w_start || (r_state == S_BUSY);

    // Store data is replicated across lanes so the byteenable alone picks the target bytes.
    always_comb begin
        w_byteenable = 4'b1111;
        w_writedata  = write_data_memory;
        case (load_store_type_memory)
            3'b001, 3'b010: begin
                w_byteenable = w_offset[1] ? 4'b1100 : 4'b0011;
                w_writedata  = {2{write_data_memory[15:0]}};
            end
            3'b011, 3'b100: begin
                w_byteenable = 4'b0001 << w_offset;
                w_writedata  = {4{write_data_memory[7:0]}};
            end
            default: begin
                w_byteenable = 4'b1111;
                w_writedata  = write_data_memory;
            end
        endcase
    end

    assign w_lane_half = r_offset[1] ? data_readdata[31:16] : data_readdata[15:0];
    assign w_lane_byte = data_readdata[{r_offset, 3'b000} +: 8];

    always_comb begin
        w_load_value = data_readdata;
        case (r_type)
            3'b001:  w_load_value = {{16{w_lane_half[15]}}, w_lane_half};
            3'b010:  w_load_value = {16'h0000, w_lane_half};
            3'b011:  w_load_value = {{24{w_lane_byte[7]}}, w_lane_byte};
            3'b100:  w_load_value = {24'h000000, w_lane_byte};
            default: w_load_value = data_readdata;
        endcase
    end

`ifdef DATA_BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_count;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state          <= S_IDLE;
            r_offset         <= 2'b00;
            r_type           <= 3'b000;
            r_is_load        <= 1'b0;
            data_address     <= 32'h0;
            data_read        <= 1'b0;
            data_write       <= 1'b0;
            data_writedata   <= 32'h0;
            data_byteenable  <= 4'h0;
            read_data_memory <= 32'h0;
`ifdef DATA_BUS_TIMEOUT_EN
            r_count            <= 8'h00;
            bus_timeout_memory <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        data_address    <= {ALU_output_memory[31:2], 2'b00};
                        data_byteenable <= w_byteenable;
                        data_writedata  <= w_writedata;
                        data_read       <= memory_to_register_memory;
                        data_write      <= memory_write_memory && !memory_to_register_memory;
                        r_offset        <= w_offset;
                        r_type          <= load_store_type_memory;
                        r_is_load       <= memory_to_register_memory;
`ifdef DATA_BUS_TIMEOUT_EN
                        r_count         <= 8'h00;
`endif
                        r_state         <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (!data_waitrequest) begin
                        data_read  <= 1'b0;
                        data_write <= 1'b0;
                        if (r_is_load) begin
                            read_data_memory <= w_load_value;
                        end
                        r_state <= S_DONE;
`ifdef DATA_BUS_TIMEOUT_EN
                    end else if (r_count == TIMEOUT_LAST) begin
                        data_read          <= 1'b0;
                        data_write         <= 1'b0;
                        read_data_memory   <= 32'hDEADBEEF;
                        bus_timeout_memory <= 1'b1;
                        r_state            <= S_DONE;
                    end else if (r_count != 8'hFF) begin
                        r_count <= r_count + 8'h01;
`endif
                    end
                end
                S_DONE: begin
`ifdef DATA_BUS_TIMEOUT_EN
                    bus_timeout_memory <= 1'b0;
`endif
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_unit.sv
// Randomized self-checking bench for memory_access_unit against an arithmetic reference model.
// Define DATA_BUS_TIMEOUT_EN to also exercise the bus watchdog (TIMEOUT_CYCLES = 4).
module tb_memory_access_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memory_to_register_memory;
    logic        memory_write_memory;
    logic [2:0]  load_store_type_memory;
    logic [31:0] ALU_output_memory;
    logic [31:0] write_data_memory;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_waitrequest;
    logic [31:0] read_data_memory;
    logic        stall_memory;
    logic        address_error_memory;
`ifdef DATA_BUS_TIMEOUT_EN
    logic        bus_timeout_memory;
`endif

    always #5 clk = ~clk;

    memory_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk                       (clk),
        .reset_n                   (reset_n),
        .memory_to_register_memory (memory_to_register_memory),
        .memory_write_memory       (memory_write_memory),
        .load_store_type_memory    (load_store_type_memory),
        .ALU_output_memory         (ALU_output_memory),
        .write_data_memory         (write_data_memory),
        .data_address              (data_address),
        .data_read                 (data_read),
        .data_write                (data_write),
        .data_writedata            (data_writedata),
        .data_byteenable           (data_byteenable),
        .data_readdata             (data_readdata),
        .data_waitrequest          (data_waitrequest),
        .read_data_memory          (read_data_memory),
        .stall_memory              (stall_memory),
`ifdef DATA_BUS_TIMEOUT_EN
        .bus_timeout_memory        (bus_timeout_memory),
`endif
        .address_error_memory      (address_error_memory)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_rdata = 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit ref_misaligned(input logic [2:0] t, input logic [31:0] a);
        if (t == 3'd0) return (a % 4) != 0;
        if (t == 3'd1 || t == 3'd2) return (a % 2) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [2:0] t, input logic [31:0] a);
        int off = int'(a % 4);
        if (t == 3'd1 || t == 3'd2) return 4'(3 << off);
        if (t == 3'd3 || t == 3'd4) return 4'(1 << off);
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] t, input logic [31:0] wd);
        if (t == 3'd1 || t == 3'd2) return (wd % 65536) * 32'h00010001;
        if (t == 3'd3 || t == 3'd4) return (wd % 256) * 32'h01010101;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        logic [31:0] v;
        sh = rd >> (8 * (a % 4));
        case (t)
            3'd1: begin v = sh % 65536; return (v >= 32768) ? v - 65536 : v; end
            3'd2: return sh % 65536;
            3'd3: begin v = sh % 256; return (v >= 128) ? v - 256 : v; end
            3'd4: return sh % 256;
            default: return rd;
        endcase
    endfunction

    task automatic do_access(input logic ld, input logic st, input logic [2:0] t,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int nwait);
        bit timeout;
        bit done;
        bit stable_ok;
        int exp_strobes;
        int strobe_cyc;
        int stall_cyc;
        timeout = 1'b0;
`ifdef DATA_BUS_TIMEOUT_EN
        timeout = (nwait >= TO);
`endif
        @(posedge clk); #1;
        memory_to_register_memory = ld;
        memory_write_memory       = st;
        load_store_type_memory    = t;
        ALU_output_memory         = a;
        write_data_memory         = wd;
        data_waitrequest          = 1'b1;
        data_readdata             = ~rd;
        if (ref_misaligned(t, a)) begin
            @(negedge clk);
            chk("misalign_err", 32'(address_error_memory), 32'd1);
            chk("misalign_stall", 32'(stall_memory), 32'd0);
            @(posedge clk); #1;
            chk("misalign_strobes", 32'({data_read, data_write}), 32'd0);
            memory_to_register_memory = 1'b0;
            memory_write_memory       = 1'b0;
            $display("txn misaligned ld=%0b st=%0b type=%0d addr=%h", ld, st, t, a);
            return;
        end
        exp_strobes = timeout ? TO : nwait + 1;
        strobe_cyc  = 0;
        stall_cyc   = 0;
        done        = 1'b0;
        stable_ok   = 1'b1;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (c == 0) chk("aligned_err", 32'(address_error_memory), 32'd0);
            if (data_read || data_write) begin
                if (data_address !== {a[31:2], 2'b00} || data_byteenable !== ref_be(t, a) ||
                    data_read !== ld || data_write !== (st && !ld) ||
                    (st && !ld && data_writedata !== ref_wdata(t, wd)))
                    stable_ok = 1'b0;
                data_waitrequest = (strobe_cyc < nwait);
                data_readdata    = (strobe_cyc < nwait) ? ~rd : rd;
                strobe_cyc++;
            end
            if (stall_memory) stall_cyc++;
            else done = 1'b1;
        end
        if (timeout) m_rdata = 32'hDEADBEEF;
        else if (ld) m_rdata = ref_load(t, a, rd);
        chk("done_reached", 32'(done), 32'd1);
        chk("stall_cycles", stall_cyc, exp_strobes + 1);
        chk("strobe_cycles", strobe_cyc, exp_strobes);
        chk("bus_stable", 32'(stable_ok), 32'd1);
        chk("done_strobes", 32'({data_read, data_write}), 32'd0);
        chk("read_data", read_data_memory, m_rdata);
`ifdef DATA_BUS_TIMEOUT_EN
        chk("timeout_pulse", 32'(bus_timeout_memory), 32'(timeout));
`endif
        @(posedge clk); #1;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        data_waitrequest          = 1'b0;
        $display("txn ld=%0b st=%0b type=%0d addr=%h wd=%h rd=%h wait=%0d result=%h stalls=%0d",
                 ld, st, t, a, wd, rd, nwait, read_data_memory, stall_cyc);
    endtask

    task automatic idle_check();
        @(posedge clk); #1;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        @(negedge clk);
        chk("idle_stall", 32'(stall_memory), 32'd0);
        chk("idle_strobes", 32'({data_read, data_write}), 32'd0);
        $display("txn idle cycle stall=%0b", stall_memory);
    endtask

    initial begin
        logic [2:0]  t;
        logic [31:0] a;
        int          kind;
        reset_n                   = 1'b0;
        memory_to_register_memory = 1'b0;
        memory_write_memory       = 1'b0;
        load_store_type_memory    = 3'd0;
        ALU_output_memory         = 32'h0;
        write_data_memory         = 32'h0;
        data_readdata             = 32'h0;
        data_waitrequest          = 1'b0;
        #2;
        chk("rst_read", 32'(data_read), 32'd0);
        chk("rst_addr", data_address, 32'h0);
        chk("rst_be", 32'(data_byteenable), 32'h0);
        chk("rst_rdata", read_data_memory, 32'h0);
        chk("rst_stall", 32'(stall_memory), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        idle_check();
        do_access(1'b1, 1'b0, 3'd0, 32'h100, 32'h0, 32'h11223344, 0);
        do_access(1'b1, 1'b0, 3'd3, 32'h103, 32'h0, 32'h80FF0000, 0);
        do_access(1'b1, 1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF0000, 0);
        do_access(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 3);
        do_access(1'b1, 1'b0, 3'd0, 32'h102, 32'h0, 32'h0, 0);
        do_access(1'b1, 1'b1, 3'd2, 32'h302, 32'h5555AAAA, 32'hC0DE8001, 1);

        // Reset in the middle of a stalled access.
        @(posedge clk); #1;
        memory_to_register_memory = 1'b1;
        load_store_type_memory    = 3'd0;
        ALU_output_memory         = 32'h300;
        data_waitrequest          = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("busy_read_before_rst", 32'(data_read), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_read", 32'(data_read), 32'd0);
        chk("async_rst_addr", data_address, 32'h0);
        chk("async_rst_rdata", read_data_memory, 32'h0);
        memory_to_register_memory = 1'b0;
        data_waitrequest          = 1'b0;
        m_rdata                   = 32'h0;
        $display("txn reset during busy");
        @(negedge clk);
        reset_n = 1'b1;
        do_access(1'b1, 1'b0, 3'd1, 32'h306, 32'h0, 32'h9ABC1234, 0);

`ifdef DATA_BUS_TIMEOUT_EN
        do_access(1'b1, 1'b0, 3'd0, 32'h400, 32'h0, 32'h12345678, 10);
`endif

        for (int i = 0; i < 40; i++) begin
            t    = 3'($urandom_range(0, 4));
            a    = $urandom;
            kind = int'($urandom_range(0, 2));
            if ($urandom_range(0, 3) != 0) begin
                if (t == 3'd0) a = a & ~32'd3;
                else if (t == 3'd1 || t == 3'd2) a = a & ~32'd1;
            end
            if (i % 10 == 0) idle_check();
            do_access(kind != 1, kind != 0, t, a, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
